uart_rx_word: RTL and testbench
===============================

// Module: uart_rx_word
// PURPOSE
//  Serial UART receiver feeding the single-cycle MIPS core's UART write port.
//  Deserializes 8N1 bytes from rx_serial and packs BIT_WIDTH/8 bytes (first byte -> LSBs).
//  Emits each full word on UART_DATA with a one-cycle W_UART strobe, which the core writes into RAM.
//  Also detects framing errors, false starts and stale partial words.
// PARAMETERS
//  BIT_WIDTH     32          word width; must be a multiple of 8 (BYTES = BIT_WIDTH/8)
//  CLK_FREQ      50_000_000  clk frequency in Hz
//  BAUD_RATE     115200      serial bit rate; CLKS_PER_BIT = CLK_FREQ/BAUD_RATE (integer div, >=4)
//  TIMEOUT_BITS  32          idle bit-times after which a partial word is discarded
// PORTS
//  clk        in   1          system clock, all logic on posedge
//  rst        in   1          asynchronous, active-low reset
//  rx_serial  in   1          asynchronous serial line, idle high
//  W_UART     out  1          one-cycle strobe: UART_DATA holds a new word
//  UART_DATA  out  BIT_WIDTH  last assembled word, held until next strobe
//  frame_err  out  1          one-cycle pulse: stop bit sampled low
//  busy       out  1          high while FSM is not in IDLE
// BEHAVIOUR
//  - Reset (rst=0): W_UART=0, UART_DATA=0, frame_err=0, busy=0, FSM=IDLE.
//    Reset also clears the byte count, shift register and timeout counter, and sets both sync flops to 1.
//    Reset mid-frame abandons the frame; no strobe is produced for a partial word.
//  - rx_serial passes through a 2-FF synchronizer; all decisions use the synced value rxs.
//  - FSM IDLE -> START when rxs==0.
//  - START: wait CLKS_PER_BIT/2 clocks, then resample rxs.
//    rxs==1 -> false start, go to IDLE with no output. rxs==0 -> DATA, bit counter reset.
//  - DATA: sample every CLKS_PER_BIT clocks, 8 bits, LSB first, into the byte register.
//    After the 8th sample -> STOP.
//  - STOP: sample after CLKS_PER_BIT clocks.
//    rxs==1: byte accepted. word_sr = {byte, word_sr[BIT_WIDTH-1:8]}; byte_cnt++. Go to IDLE.
//    rxs==0: frame_err pulses 1 cycle. Byte dropped, byte_cnt=0, word_sr=0. Go to BREAK.
//  - BREAK: wait for rxs==1, then IDLE. A line held low never retriggers START.
//  - Word complete: when byte_cnt reaches BYTES, on the accepting edge byte_cnt wraps to 0.
//    On the next edge, UART_DATA<=word_sr and W_UART=1 for exactly one cycle.
//    Latency is 1 clk after the stop-bit sample edge.
//  - Back-to-back frames, where the next start bit follows the stop bit immediately, are received without loss.
//    The strobe does not stall reception.
//  - Timeout: with FSM in IDLE and byte_cnt!=0, count clocks. Any start bit resets the count.
//    At TIMEOUT_BITS*CLKS_PER_BIT clocks: byte_cnt=0, word_sr=0, no strobe, no frame_err.
//  - Counter widths are $clog2 of their max value +1. All arithmetic is unsigned and wraps only as stated.
//  - W_UART and frame_err are never high in the same cycle: a frame error can only follow a new start bit.
// STRUCTURE
//  - uart_pkg holds:
//    - typedef enum {IDLE, START, DATA, STOP, BREAK} uart_rx_state_t
//    - function clks_per_bit(clk_freq, baud)
//    - localparam UART_DATA_BITS = 8
//  - Sub-module uart_rx_byte contains the synchronizer, FSM and baud counter.
//    It outputs byte_valid, byte_data[7:0], frame_err and busy.
//  - uart_rx_word itself holds the byte counter, word shift register, timeout counter and output registers.
// TESTING (sim params: CLK_FREQ=1_600_000, BAUD_RATE=100_000 -> CLKS_PER_BIT=16, TIMEOUT_BITS=32)
//  1. Send 0x78,0x56,0x34,0x12 with 2-bit gaps.
//     -> exactly one W_UART pulse, UART_DATA=0x12345678, frame_err never high.
//  2. Drive rx_serial low for 4 clks, then high.
//     -> no W_UART, no frame_err, busy back to 0 by clk 12.
//  3. Send 0x11, then 0x22 with stop bit=0, then 0xEF,0xBE,0xAD,0xDE.
//     -> one frame_err pulse, then single W_UART with UART_DATA=0xDEADBEEF.
//  4. Send 0xAA,0xBB, idle 40 bit-times, then 0x01,0x02,0x03,0x04.
//     -> single W_UART, UART_DATA=0x04030201.
//  5. After a word 0xCAFEF00D, assert rst during bit 3 of the next byte 2, release, send 0x01..0x04.
//     -> UART_DATA=0 and W_UART=0 during reset, then 0x04030201 after release.
//  6. Send 8 back-to-back frames 0x00..0x07 with zero gap.
//     -> two W_UART pulses, UART_DATA 0x03020100 then 0x07060504.

Source files
------------

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared types and helpers for the UART word receiver
package uart_pkg;

  localparam int UART_DATA_BITS = 8;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    BREAK = 3'd4
  } uart_rx_state_t;

  function automatic int clks_per_bit(input int clk_freq, input int baud);
    return clk_freq / baud;
  endfunction

endpackage

// File: rtl/uart_rx_byte.sv
// rtl/uart_rx_byte.sv - 8N1 byte deserializer: synchronizer, bit FSM and baud counter
module uart_rx_byte
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_serial,
  output logic       byte_valid,
  output logic [7:0] byte_data,
  output logic       frame_err,
  output logic       busy
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT) + 1;
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  logic           rx_meta;
  logic           rxs;
  uart_rx_state_t state;
  logic [CNT_W-1:0] cnt;
  logic [3:0]     bit_idx;
  logic [7:0]     shreg;
  logic           stop_tick;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_meta <= 1'b1;
      rxs     <= 1'b1;
    end else begin
      rx_meta <= rx_serial;
      rxs     <= rx_meta;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      shreg   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (!rxs) begin
            state <= START;
            cnt   <= '0;
          end
        end
        START: begin
          // Mid-bit recheck filters glitches shorter than half a bit
          if (cnt == HALF_LAST) begin
            cnt     <= '0;
            bit_idx <= '0;
            state   <= rxs ? IDLE : DATA;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        DATA: begin
          if (cnt == BIT_LAST) begin
            cnt     <= '0;
            shreg   <= {rxs, shreg[7:1]};
            bit_idx <= bit_idx + 4'd1;
            if (bit_idx == 4'd7) state <= STOP;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        STOP: begin
          if (cnt == BIT_LAST) begin
            cnt   <= '0;
            state <= rxs ? IDLE : BREAK;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        BREAK: begin
          if (rxs) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Valid/error are flagged on the stop-sample edge itself so the word logic loses no cycle
  assign stop_tick  = (state == STOP) && (cnt == BIT_LAST);
  assign byte_valid = stop_tick && rxs;
  assign frame_err  = stop_tick && !rxs;
  assign byte_data  = shreg;
  assign busy       = (state != IDLE);

endmodule

// File: rtl/uart_rx_word.sv
// rtl/uart_rx_word.sv - packs received UART bytes into words for the core's write port
module uart_rx_word
  import uart_pkg::*;
#(
  parameter int BIT_WIDTH    = 32,
  parameter int CLK_FREQ     = 50_000_000,
  parameter int BAUD_RATE    = 115200,
  parameter int TIMEOUT_BITS = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx_serial,
  output logic                 W_UART,
  output logic [BIT_WIDTH-1:0] UART_DATA,
  output logic                 frame_err,
  output logic                 busy
);

  localparam int CPB      = clks_per_bit(CLK_FREQ, BAUD_RATE);
  localparam int BYTES    = BIT_WIDTH / UART_DATA_BITS;
  localparam int BCNT_W   = $clog2(BYTES) + 1;
  localparam int TO_LIMIT = TIMEOUT_BITS * CPB;
  localparam int TO_W     = $clog2(TO_LIMIT) + 1;
  localparam logic [BCNT_W-1:0] BCNT_LAST = BCNT_W'(BYTES - 1);
  localparam logic [TO_W-1:0]   TO_LAST   = TO_W'(TO_LIMIT - 1);

  logic                 byte_valid;
  logic [7:0]           byte_data;
  logic                 byte_ferr;
  logic [BCNT_W-1:0]    byte_cnt;
  logic [BIT_WIDTH-1:0] word_sr;
  logic [TO_W-1:0]      tcnt;
  logic                 word_done;

  uart_rx_byte #(
    .CLKS_PER_BIT(CPB)
  ) u_rx_byte (
    .clk       (clk),
    .rst       (rst),
    .rx_serial (rx_serial),
    .byte_valid(byte_valid),
    .byte_data (byte_data),
    .frame_err (byte_ferr),
    .busy      (busy)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      W_UART    <= 1'b0;
      UART_DATA <= '0;
      frame_err <= 1'b0;
      byte_cnt  <= '0;
      word_sr   <= '0;
      tcnt      <= '0;
      word_done <= 1'b0;
    end else begin
      W_UART    <= word_done;
      frame_err <= byte_ferr;
      word_done <= 1'b0;
      if (word_done) UART_DATA <= word_sr;

      if (byte_valid) begin
        word_sr <= {byte_data, word_sr[BIT_WIDTH-1:8]};
        tcnt    <= '0;
        if (byte_cnt == BCNT_LAST) begin
          byte_cnt  <= '0;
          word_done <= 1'b1;
        end else begin
          byte_cnt <= byte_cnt + BCNT_W'(1);
        end
      end else if (byte_ferr) begin
        byte_cnt <= '0;
        word_sr  <= '0;
        tcnt     <= '0;
      end else if (busy || byte_cnt == '0) begin
        tcnt <= '0;
      end else if (tcnt == TO_LAST) begin
        // Line idle too long mid-word: the sender gave up, drop the partial word
        byte_cnt <= '0;
        word_sr  <= '0;
        tcnt     <= '0;
      end else begin
        tcnt <= tcnt + TO_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_word.sv
// tb/tb_uart_rx_word.sv - randomized and directed bench for uart_rx_word
module tb_uart_rx_word;

  localparam int CPB = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        rx_serial;
  logic        W_UART;
  logic [31:0] UART_DATA;
  logic        frame_err;
  logic        busy;

  uart_rx_word #(
    .BIT_WIDTH   (32),
    .CLK_FREQ    (1_600_000),
    .BAUD_RATE   (100_000),
    .TIMEOUT_BITS(32)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .rx_serial(rx_serial),
    .W_UART   (W_UART),
    .UART_DATA(UART_DATA),
    .frame_err(frame_err),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  logic [31:0] obs_q[$];
  int ferr_seen = 0;
  int overlap   = 0;

  always @(negedge clk) begin
    if (W_UART) obs_q.push_back(UART_DATA);
    if (frame_err) ferr_seen++;
    if (W_UART && frame_err) overlap++;
  end

  // Reference model: bytes gathered per word, words and frame errors expected
  logic [7:0]  part_q[$];
  logic [31:0] exp_q[$];
  int          exp_ferr = 0;
  logic [31:0] exp_last = 32'h0;

  task automatic model_accept(input logic [7:0] b);
    logic [31:0] w;
    part_q.push_back(b);
    if (part_q.size() == 4) begin
      w = 32'h0;
      for (int i = 0; i < 4; i++) w = w + (32'(part_q[i]) << (8 * i));
      exp_q.push_back(w);
      exp_last = w;
      part_q.delete();
    end
  endtask

  task automatic wait_clks(input int n);
    if (n > 0) begin
      repeat (n) @(posedge clk);
      #1;
    end
  endtask

  task automatic send_byte(input logic [7:0] data, input logic stop, input int gap);
    rx_serial = 1'b0;
    wait_clks(CPB);
    check("busy_in_frame", {31'b0, busy}, 32'h1);
    for (int i = 0; i < 8; i++) begin
      rx_serial = data[i];
      wait_clks(CPB);
    end
    rx_serial = stop;
    wait_clks(CPB);
    rx_serial = 1'b1;
    wait_clks(gap * CPB);
    if (stop) model_accept(data);
    else begin
      part_q.delete();
      exp_ferr++;
    end
    if (gap >= 32) part_q.delete();
  endtask

  task automatic scenario_end(input string tag);
    wait_clks(40 * CPB);
    part_q.delete();
    check({tag, "_nwords"}, obs_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++)
      check({tag, "_word"}, (i < obs_q.size()) ? obs_q[i] : 32'hxxxxxxxx, exp_q[i]);
    check({tag, "_nferr"}, ferr_seen, exp_ferr);
    check({tag, "_held"}, UART_DATA, exp_last);
    obs_q.delete();
    exp_q.delete();
    ferr_seen = 0;
    exp_ferr  = 0;
  endtask

  initial begin
    rst       = 1'b0;
    rx_serial = 1'b1;
    wait_clks(3);
    check("rst_w_uart", {31'b0, W_UART}, 32'h0);
    check("rst_data", UART_DATA, 32'h0);
    check("rst_ferr", {31'b0, frame_err}, 32'h0);
    check("rst_busy", {31'b0, busy}, 32'h0);
    rst = 1'b1;
    wait_clks(2);

    send_byte(8'h78, 1'b1, 2);
    send_byte(8'h56, 1'b1, 2);
    send_byte(8'h34, 1'b1, 2);
    send_byte(8'h12, 1'b1, 2);
    scenario_end("s1");

    rx_serial = 1'b0;
    wait_clks(4);
    rx_serial = 1'b1;
    wait_clks(8);
    check("false_start_busy", {31'b0, busy}, 32'h0);
    scenario_end("s2");

    send_byte(8'h11, 1'b1, 2);
    send_byte(8'h22, 1'b0, 2);
    send_byte(8'hEF, 1'b1, 2);
    send_byte(8'hBE, 1'b1, 2);
    send_byte(8'hAD, 1'b1, 2);
    send_byte(8'hDE, 1'b1, 2);
    scenario_end("s3");

    send_byte(8'hAA, 1'b1, 2);
    send_byte(8'hBB, 1'b1, 40);
    for (int i = 1; i <= 4; i++) send_byte(8'(i), 1'b1, 2);
    scenario_end("s4");

    send_byte(8'h10, 1'b1, 31);
    send_byte(8'h20, 1'b1, 2);
    send_byte(8'h30, 1'b1, 32);
    send_byte(8'h40, 1'b1, 2);
    send_byte(8'h50, 1'b1, 2);
    send_byte(8'h60, 1'b1, 2);
    send_byte(8'h70, 1'b1, 2);
    scenario_end("tmo_edge");

    send_byte(8'h0D, 1'b1, 2);
    send_byte(8'hF0, 1'b1, 2);
    send_byte(8'hFE, 1'b1, 2);
    send_byte(8'hCA, 1'b1, 2);
    send_byte(8'h99, 1'b1, 2);
    rx_serial = 1'b0;
    wait_clks(CPB);
    for (int i = 0; i < 3; i++) begin
      rx_serial = (i == 0);
      wait_clks(CPB);
    end
    rx_serial = 1'b0;
    wait_clks(CPB / 2);
    rst = 1'b0;
    part_q.delete();
    exp_last = 32'h0;
    wait_clks(2);
    check("midrst_w_uart", {31'b0, W_UART}, 32'h0);
    check("midrst_data", UART_DATA, 32'h0);
    check("midrst_busy", {31'b0, busy}, 32'h0);
    check("midrst_ferr", {31'b0, frame_err}, 32'h0);
    rx_serial = 1'b1;
    wait_clks(CPB);
    rst = 1'b1;
    wait_clks(2 * CPB);
    for (int i = 1; i <= 4; i++) send_byte(8'(i), 1'b1, 2);
    scenario_end("s5");

    for (int i = 0; i < 8; i++) send_byte(8'(i), 1'b1, 0);
    scenario_end("s6");

    for (int n = 0; n < 48; n++) begin
      logic [7:0] d;
      logic       s;
      int         r;
      int         g;
      d = 8'($urandom_range(0, 255));
      s = ($urandom_range(0, 9) != 0);
      r = $urandom_range(0, 7);
      g = (r < 4) ? r : ((r == 7) ? 40 : 2);
      if (!s && g == 0) g = 1;
      send_byte(d, s, g);
    end
    scenario_end("rand");

    check("strobe_ferr_overlap", overlap, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
